// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline stage with a 2-entry skid buffer, stall and flush.
// Define PIPE_SKID_STATS_EN to add the stall_cnt / flush_cnt statistics outputs.
module pipe_skid_stage #(
    parameter int DATA_W         = 70,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              stg_clk,
    input  logic              reset_n,
    input  logic              stg_ena,
    input  logic              stg_x,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);
    logic              main_v, skid_v, main_v_n, skid_v_n;
    logic [DATA_W-1:0] main_d, skid_d, main_d_n, skid_d_n;
    logic              push, pop;
    always_ff @(posedge stg_clk or negedge reset_n) begin
        if (!reset_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= '0;
            skid_d <= '0;
        end else begin
            main_v <= main_v_n;
            skid_v <= skid_v_n;
            main_d <= main_d_n;
            skid_d <= skid_d_n;
        end
    end
    // push/pop already carry the stall and flush gating through in_ready/out_valid
    always_comb begin
        main_v_n = main_v;
        skid_v_n = skid_v;
        main_d_n = main_d;
        skid_d_n = skid_d;
        if (stg_x) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
            main_d_n = CLEAR_ON_FLUSH ? '0 : main_d;
            skid_d_n = CLEAR_ON_FLUSH ? '0 : skid_d;
        end else if (skid_v) begin
            if (pop) begin
                main_d_n = skid_d;
                skid_v_n = 1'b0;
            end
        end else if (main_v) begin
            if (push && pop) begin
                main_d_n = in_data;
            end else if (push) begin
                skid_v_n = 1'b1;
                skid_d_n = in_data;
            end else if (pop) begin
                main_v_n = 1'b0;
            end
        end else if (push) begin
            main_v_n = 1'b1;
            main_d_n = in_data;
        end
    end
    // reset_n gating keeps both handshakes low while reset is held
    always_comb begin
        in_ready  = reset_n & ~skid_v & stg_ena & ~stg_x;
        out_valid = reset_n & main_v & stg_ena & ~stg_x;
        out_data  = main_d;
        occupancy = {1'b0, main_v} + {1'b0, skid_v};
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end
`ifdef PIPE_SKID_STATS_EN
    always_ff @(posedge stg_clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (stg_x && occupancy != 2'd0 && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: scoreboard bench for pipe_skid_stage.
// Define PIPE_SKID_STATS_EN to also check the statistics counters.
module tb_pipe_skid_stage;
    localparam int W = 70;
    logic         stg_clk = 1'b0;
    logic         reset_n, stg_ena, stg_x, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
`ifdef PIPE_SKID_STATS_EN
    logic [15:0]  stall_cnt, flush_cnt;
`endif
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           failures = 0;

    pipe_skid_stage #(.DATA_W(W), .CLEAR_ON_FLUSH(1'b1)) dut (
        .stg_clk(stg_clk), .reset_n(reset_n), .stg_ena(stg_ena), .stg_x(stg_x),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy)
`ifdef PIPE_SKID_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 stg_clk = ~stg_clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // monitor: every delivered entry must match the head of the scoreboard
    always @(negedge stg_clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output got=%0h expected=none", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [W-1:0] d);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge stg_clk);
        while (!in_ready && n < 20) begin
            @(negedge stg_clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout_in_ready", in_ready, 1);
        end else begin
            exp_q.push_back(d);
        end
        @(posedge stg_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic fill_ab();
        out_ready = 1'b0;
        send(70'hA);
        send(70'hB);
    endtask

    initial begin
        reset_n = 1'b0; stg_ena = 1'b1; stg_x = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge stg_clk); #1;
        reset_n = 1'b1;
        @(negedge stg_clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge stg_clk); #1;

        // streaming: one entry per cycle, 1-cycle latency
        for (int i = 1; i <= 8; i++) begin
            in_data = W'(i);
            in_valid = 1'b1;
            @(negedge stg_clk);
            chk("stream_in_ready", in_ready, 1);
            exp_q.push_back(W'(i));
            if (i > 1) begin
                chk("stream_out_valid", out_valid, 1);
                chk("stream_occupancy", occupancy, 1);
            end
            @(posedge stg_clk); #1;
        end
        in_valid = 1'b0;
        @(posedge stg_clk);
        @(negedge stg_clk);
        chk("stream_drained_occ", occupancy, 0);
        chk("stream_drained_q", exp_q.size(), 0);
        @(posedge stg_clk); #1;

        // backpressure into FULL, then drain
        fill_ab();
        @(negedge stg_clk);
        chk("full_occupancy", occupancy, 2);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_data", out_data, 70'hA);
        chk("full_out_valid", out_valid, 1);
        @(posedge stg_clk); #1;
        out_ready = 1'b1;
        repeat (2) @(posedge stg_clk);
        @(negedge stg_clk);
        chk("drain_occupancy", occupancy, 0);
        chk("drain_q", exp_q.size(), 0);
        @(posedge stg_clk); #1;

        // stall while FULL
        fill_ab();
        out_ready = 1'b1;
        stg_ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge stg_clk);
            chk("stall_out_valid", out_valid, 0);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_occupancy", occupancy, 2);
        end
        @(posedge stg_clk); #1;
        stg_ena = 1'b1;
        repeat (2) @(posedge stg_clk);
        @(negedge stg_clk);
        chk("stall_drain_occ", occupancy, 0);
        chk("stall_drain_q", exp_q.size(), 0);
        @(posedge stg_clk); #1;

        // flush while FULL with an upstream entry offered
        fill_ab();
        in_valid = 1'b1;
        in_data = 70'hC;
        stg_x = 1'b1;
        @(negedge stg_clk);
        chk("flush_in_ready", in_ready, 0);
        chk("flush_out_valid", out_valid, 0);
        @(posedge stg_clk); #1;
        stg_x = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge stg_clk);
        chk("flush_occupancy", occupancy, 0);
        chk("flush_out_valid_after", out_valid, 0);
        chk("flush_out_data_zero", out_data, 0);
        out_ready = 1'b1;
        repeat (3) @(negedge stg_clk);
        chk("flush_no_leak_occ", occupancy, 0);
        @(posedge stg_clk); #1;

        // asynchronous reset while FULL, away from the clock edge
        fill_ab();
        @(negedge stg_clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_occupancy", occupancy, 0);
        chk("arst_out_data", out_data, 0);
        exp_q.delete();
        @(posedge stg_clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        send(70'h55);
        send(70'h66);
        repeat (2) @(posedge stg_clk);
        @(negedge stg_clk);
        chk("arst_resume_q", exp_q.size(), 0);
        chk("arst_resume_occ", occupancy, 0);

`ifdef PIPE_SKID_STATS_EN
        @(posedge stg_clk); #1;
        reset_n = 1'b0;
        #1;
        chk("stats_rst_stall", stall_cnt, 0);
        chk("stats_rst_flush", flush_cnt, 0);
        reset_n = 1'b1;
        out_ready = 1'b0;
        send(70'h11);
        repeat (5) @(posedge stg_clk);
        @(negedge stg_clk);
        chk("stall_cnt_5", stall_cnt, 5);
        @(posedge stg_clk); #1;
        stg_x = 1'b1;
        @(posedge stg_clk); #1;
        stg_x = 1'b0;
        send(70'h22);
        stg_x = 1'b1;
        @(posedge stg_clk); #1;
        stg_x = 1'b1;
        @(posedge stg_clk); #1;
        stg_x = 1'b0;
        exp_q.delete();
        @(negedge stg_clk);
        chk("flush_cnt_2", flush_cnt, 2);
        @(posedge stg_clk); #1;
        send(70'h33);
        repeat (65600) @(posedge stg_clk);
        @(negedge stg_clk);
        chk("stall_cnt_sat", stall_cnt, 16'hFFFF);
        @(posedge stg_clk); #1;
        stg_x = 1'b1;
        @(posedge stg_clk); #1;
        stg_x = 1'b0;
        exp_q.delete();
        @(negedge stg_clk);
        chk("stall_cnt_not_flushed", stall_cnt, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised successor to the fixed-field inter-stage latch. Carries an arbitrary-width stage payload, e.g. PC, branch target, branch flags and predictor counter/valid/prediction packed into one bus.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the upstream stage sees a registered ready.
- Adds a global stage-enable (stall) and a synchronous flush that squashes in-flight entries.
- Sits between any two pipeline stages, e.g. address and decode.

Parameters:
- DATA_W, 70, payload width in bits (default = 32+32+2+2+1+1).
- CLEAR_ON_FLUSH, 1. 1: flush zeroes the data registers. 0: flush clears only the valid bits.

Ports:
- stg_clk  in  1  stage clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stg_ena  in  1  stage enable. 0 = stall; state frozen.
- stg_x  in  1  synchronous flush; squashes all entries.
- in_valid  in  1  upstream entry valid.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept an entry.
- out_valid  out  1  downstream entry valid.
- out_data  out  DATA_W  downstream payload.
- out_ready  in  1  downstream accepts the entry.
- occupancy  out  2  number of held entries (0..2).

Behaviour:
- Storage: main register (main_v, main_d) drives the output; skid register (skid_v, skid_d) holds overflow.
- States: EMPTY (main_v=0), ONE (main_v=1, skid_v=0), FULL (main_v=1, skid_v=1).
- Outputs:
  - in_ready = ~skid_v & stg_ena & ~stg_x. Derived from registered state plus the two control inputs only; never depends on out_ready.
  - out_valid = main_v & stg_ena & ~stg_x.
  - out_data = main_d (valid or not).
  - occupancy = main_v + skid_v.
- Handshakes: push = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions (stg_ena=1, stg_x=0):
  - EMPTY: push -> ONE, main_d<=in_data.
  - ONE: push&pop -> ONE, main_d<=in_data. push only -> FULL, skid_d<=in_data. pop only -> EMPTY. Neither -> hold.
  - FULL: pop -> ONE, main_d<=skid_d, skid_v<=0. No push is possible (in_ready=0).
- Ordering: entries leave in arrival order; no entry is duplicated or dropped except by flush.
- Latency: 1 cycle from a push into EMPTY to out_valid. Throughput of 1 entry/cycle when out_ready is held high.
- Stall (stg_ena=0, stg_x=0):
  - All registers hold.
  - in_ready=0 and out_valid=0, so no handshake can occur.
  - Upstream must hold in_valid/in_data; downstream must ignore out_data.
- Flush (stg_x=1):
  - Takes priority over stg_ena and all handshakes.
  - Next edge: main_v=0, skid_v=0. Data zeroed if CLEAR_ON_FLUSH=1, held otherwise.
  - During the flush cycle in_ready=0 and out_valid=0, so nothing is accepted or delivered.
- Reset (reset_n=0, any time incl. mid-transfer):
  - Immediately main_v=skid_v=0, main_d=skid_d=0.
  - Outputs: in_ready=0, out_valid=0, out_data=0, occupancy=0.
  - After release, in_ready rises combinationally with stg_ena=1 and stg_x=0.
- No X propagation: out_data is always a register value.

Optional Feature:
- Macro PIPE_SKID_STATS_EN.
- Defined:
  - Adds output stall_cnt (16 bits): increments each cycle out_valid=1 & out_ready=0.
  - Adds output flush_cnt (16 bits): increments on each flush edge where occupancy>0.
  - Both saturate at 16'hFFFF and reset to 0 on reset_n=0.
  - Neither is cleared by stg_x.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then stg_ena=1, in_valid=1, in_data=0x1, out_ready=1 -> next cycle out_valid=1, out_data=0x1, occupancy=1. Streaming 0x1..0x8 emerges in order at 1 entry/cycle.
- out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0, out_data=0xA. Then out_ready=1 -> 0xA, then 0xB, then occupancy=0.
- In FULL, stg_ena=0 for 3 cycles with out_ready=1 -> out_valid=0, in_ready=0, occupancy stays 2, no data loss. Re-enable -> 0xA, 0xB delivered.
- FULL, assert stg_x with in_valid=1, in_data=0xC -> next cycle occupancy=0, out_valid=0. 0xC is never output. Data regs read 0 with CLEAR_ON_FLUSH=1.
- Assert reset_n=0 mid-edge while FULL -> outputs zero without a clock edge. After release the stage accepts new data normally.
- With PIPE_SKID_STATS_EN: hold out_ready=0 with main valid for 5 cycles -> stall_cnt=5. Two flushes with entries plus one while EMPTY -> flush_cnt=2. Forced saturation stays at 0xFFFF.
